// File: rtl/example_serdes_pkg.sv
// Shared definitions for the example SerDes lane.
//   align_state_t / ST_*  : word-alignment FSM states (SEARCH, VERIFY, LOCKED)
//   DEFAULT_COMMA         : 10-bit idle/alignment symbol
//   clog2()               : counter width helper
package example_serdes_pkg;

  typedef logic [1:0] align_state_t;

  localparam align_state_t ST_SEARCH = 2'd0;
  localparam align_state_t ST_VERIFY = 2'd1;
  localparam align_state_t ST_LOCKED = 2'd2;

  localparam logic [9:0] DEFAULT_COMMA = 10'b0011111010;

  // Smallest r with 2**r >= v (at least 1 so counters are never zero-width).
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/example_serdes_if.sv
// Word-side bus of the SerDes lane: ready/valid transmit words and
// received-word strobes.
//   master : lane logic (drives txData/txValid, observes the rest)
//   slave  : the SerDes lane itself
interface example_serdes_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] txData;
  logic              txValid;
  logic              txReady;
  logic [DATA_W-1:0] rxData;
  logic              rxValid;
  logic              rxComma;

  modport master (
    output txData, txValid,
    input  txReady, rxData, rxValid, rxComma
  );

  modport slave (
    input  txData, txValid,
    output txReady, rxData, rxValid, rxComma
  );
endinterface

// File: rtl/example_serdes_align.sv
// Receive side of the lane: 2*DATA_W-bit sampling window, word-boundary
// counter with bit-slip, and the SEARCH/VERIFY/LOCKED alignment FSM.
// Ports:
//   clk, rst_n   : bit clock, synchronous active-low reset
//   rx_i         : serial input bit
//   realign_i    : force SEARCH and clear counters (any cycle)
//   rxData_o     : last aligned word (VERIFY/LOCKED boundaries)
//   rxValid_o    : pulse, non-comma word while LOCKED
//   rxComma_o    : pulse, aligned word equals COMMA
//   locked_o     : FSM is in LOCKED
module example_serdes_align
  import example_serdes_pkg::*;
#(
  parameter int                DATA_W      = 10,
  parameter logic [DATA_W-1:0] COMMA       = DATA_W'(DEFAULT_COMMA),
  parameter int                ALIGN_COUNT = 4,
  parameter int                LOSS_COUNT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  input  logic              realign_i,
  output logic [DATA_W-1:0] rxData_o,
  output logic              rxValid_o,
  output logic              rxComma_o,
  output logic              locked_o
);

  localparam int                CW         = clog2(DATA_W);
  localparam int                MW         = clog2(ALIGN_COUNT + 1);
  localparam int                LW         = clog2(LOSS_COUNT + 1);
  localparam logic [CW-1:0]     LAST       = CW'(DATA_W - 1);
  localparam logic [MW-1:0]     ALIGN_M    = MW'(ALIGN_COUNT);
  localparam logic [MW-1:0]     ALIGN_LAST = MW'(ALIGN_COUNT - 1);
  localparam logic [LW-1:0]     LOSS_M     = LW'(LOSS_COUNT);
  localparam logic [LW-1:0]     LOSS_LAST  = LW'(LOSS_COUNT - 1);

  logic [2*DATA_W-1:0] win_q;
  logic [CW-1:0]       rxBitCnt_q, rxBitCnt_d;
  logic                hold_q, hold_d;
  align_state_t        state_q, state_d;
  logic [MW-1:0]       matchCnt_q, matchCnt_d;
  logic [LW-1:0]       missCnt_q, missCnt_d;
  logic [DATA_W-1:0]   rxData_q, rxData_d;
  logic                rxValid_q, rxValid_d;
  logic                rxComma_q, rxComma_d;

  logic [DATA_W-1:0]   word;
  logic                boundary, isComma, offComma, slip;

  assign word     = win_q[DATA_W-1:0];
  // The cycle after a slip keeps the counter at LAST but is not a boundary,
  // so the following boundary lands one bit later.
  assign boundary = (rxBitCnt_q == LAST) && !hold_q;
  assign isComma  = (word == COMMA);

  // A comma sitting at a nonzero bit offset means the link drifted.
  always_comb begin
    offComma = 1'b0;
    for (int k = 1; k < DATA_W; k++) begin
      if (win_q[k +: DATA_W] == COMMA) offComma = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    matchCnt_d = matchCnt_q;
    missCnt_d  = missCnt_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    rxComma_d  = 1'b0;
    slip       = 1'b0;
    if (boundary) begin
      rxComma_d = isComma;
      rxValid_d = (state_q == ST_LOCKED) && !isComma;
      if (state_q == ST_LOCKED || state_q == ST_VERIFY) rxData_d = word;
      case (state_q)
        ST_SEARCH: begin
          if (isComma) begin
            matchCnt_d = MW'(1);
            state_d    = (ALIGN_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
            missCnt_d  = '0;
          end else begin
            slip = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (isComma) begin
            if (matchCnt_q != ALIGN_M) matchCnt_d = matchCnt_q + 1'b1;
            if (matchCnt_q >= ALIGN_LAST) begin
              state_d   = ST_LOCKED;
              missCnt_d = '0;
            end
          end else begin
            state_d    = ST_SEARCH;
            matchCnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (isComma) begin
            missCnt_d = '0;
          end else if (offComma) begin
            if (missCnt_q != LOSS_M) missCnt_d = missCnt_q + 1'b1;
            if (missCnt_q >= LOSS_LAST) begin
              state_d    = ST_SEARCH;
              matchCnt_d = '0;
              missCnt_d  = '0;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
    // realign overrides any boundary decision made above
    if (realign_i) begin
      state_d    = ST_SEARCH;
      matchCnt_d = '0;
      missCnt_d  = '0;
    end
  end

  always_comb begin
    if (boundary && slip) begin
      rxBitCnt_d = rxBitCnt_q;
      hold_d     = 1'b1;
    end else begin
      rxBitCnt_d = (rxBitCnt_q == LAST) ? '0 : rxBitCnt_q + 1'b1;
      hold_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q      <= '0;
      rxBitCnt_q <= '0;
      hold_q     <= 1'b0;
      state_q    <= ST_SEARCH;
      matchCnt_q <= '0;
      missCnt_q  <= '0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      rxComma_q  <= 1'b0;
    end else begin
      win_q      <= {win_q[2*DATA_W-2:0], rx_i};
      rxBitCnt_q <= rxBitCnt_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      matchCnt_q <= matchCnt_d;
      missCnt_q  <= missCnt_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      rxComma_q  <= rxComma_d;
    end
  end

  assign rxData_o  = rxData_q;
  assign rxValid_o = rxValid_q;
  assign rxComma_o = rxComma_q;
  assign locked_o  = (state_q == ST_LOCKED);

endmodule

// File: rtl/example_serdes_lane.sv
// Single-lane SerDes: MSB-first serializer with ready/valid word input and
// idle-comma insertion, plus comma-aligned deserializer (example_serdes_align).
// Ports:
//   fastClk    : bit clock, all logic on posedge
//   resetIn_n  : synchronous active-low reset
//   bus        : example_serdes_if.slave (txData/txValid/txReady,
//                rxData/rxValid/rxComma)
//   tx_p, tx_n : serial output pair (tx_n = ~tx_p)
//   rx_p       : serial input
//   realign    : force alignment back to SEARCH
//   locked     : alignment FSM is in LOCKED
//   loopback   : only with HBWIF_SERDES_LOOPBACK_EN defined; selects the
//                internal tx_p as deserializer input
module example_serdes_lane
  import example_serdes_pkg::*;
#(
  parameter int                DATA_W      = 10,
  parameter logic [DATA_W-1:0] COMMA       = DATA_W'(DEFAULT_COMMA),
  parameter int                ALIGN_COUNT = 4,
  parameter int                LOSS_COUNT  = 3
) (
  input  logic   fastClk,
  input  logic   resetIn_n,
  example_serdes_if.slave bus,
  output logic   tx_p,
  output logic   tx_n,
  input  logic   rx_p,
  input  logic   realign,
  output logic   locked
`ifdef HBWIF_SERDES_LOOPBACK_EN
  ,
  input  logic   loopback
`endif
);

  localparam int            CW   = clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [CW-1:0]     txBitCnt_q, txBitCnt_d;
  logic [DATA_W-1:0] txShift_q, txShift_d;
  logic              txLoad;
  logic              rxIn;

  // The last bit slot of a word is the only cycle a new word can be taken;
  // with nothing offered the comma keeps the link trained.
  assign txLoad = (txBitCnt_q == LAST);

  always_comb begin
    txBitCnt_d = txLoad ? '0 : txBitCnt_q + 1'b1;
    if (txLoad) txShift_d = bus.txValid ? bus.txData : COMMA;
    else        txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge fastClk) begin
    if (!resetIn_n) begin
      txBitCnt_q <= '0;
      txShift_q  <= '0;
    end else begin
      txBitCnt_q <= txBitCnt_d;
      txShift_q  <= txShift_d;
    end
  end

  assign bus.txReady = txLoad;
  assign tx_p        = txShift_q[DATA_W-1];
  assign tx_n        = ~tx_p;

`ifdef HBWIF_SERDES_LOOPBACK_EN
  assign rxIn = loopback ? tx_p : rx_p;
`else
  assign rxIn = rx_p;
`endif

  example_serdes_align #(
    .DATA_W      (DATA_W),
    .COMMA       (COMMA),
    .ALIGN_COUNT (ALIGN_COUNT),
    .LOSS_COUNT  (LOSS_COUNT)
  ) u_align (
    .clk       (fastClk),
    .rst_n     (resetIn_n),
    .rx_i      (rxIn),
    .realign_i (realign),
    .rxData_o  (bus.rxData),
    .rxValid_o (bus.rxValid),
    .rxComma_o (bus.rxComma),
    .locked_o  (locked)
  );

endmodule
